// File: rtl/singcyc_periph_bus.sv
// singcyc_periph_bus: data-side bus between the single-cycle core and RAM/peripherals.
// Decodes RAM vs. memory-mapped timer, LED, switch, 7-seg and optional UART TX.
// Optional feature: define UART_TX_EN to build the UART transmitter (0x18/0x1C).
// Ports:
//   iClk, iRst_n            clock, async active-low reset
//   iAddr, iMemRead,
//   iMemWrite, iWrData      core data-memory port
//   oRdData                 combinational load data
//   oRamWrite, iRamRdData   external data RAM write enable / read data
//   iSwitch                 board switches (synchronised internally)
//   oLed, oDigi             LED and 7-seg registers
//   oIrq                    timer interrupt request
//   oUartTx                 UART serial out, idle high
module singcyc_periph_bus #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic [31:0] iAddr,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iWrData,
    output logic [31:0] oRdData,
    output logic        oRamWrite,
    input  logic [31:0] iRamRdData,
    input  logic [7:0]  iSwitch,
    output logic [7:0]  oLed,
    output logic [11:0] oDigi,
    output logic        oIrq,
    output logic        oUartTx
);

    logic       ramSel;
    logic       perSel;
    logic       perWr;
    logic [5:0] offs;

    assign ramSel    = (iAddr[31:30] == 2'b00);
    assign perSel    = (iAddr[31:8] == 24'h400000);
    assign perWr     = iMemWrite & perSel;
    assign offs      = iAddr[7:2];
    assign oRamWrite = iMemWrite & ramSel;

    logic wrTh, wrTl, wrTcon, wrLed, wrDigi;

    assign wrTh   = perWr & (offs == 6'h00);
    assign wrTl   = perWr & (offs == 6'h01);
    assign wrTcon = perWr & (offs == 6'h02);
    assign wrLed  = perWr & (offs == 6'h03);
    assign wrDigi = perWr & (offs == 6'h05);

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [7:0]  sw1;
    logic [7:0]  sw2;
    logic        tlMax;

    assign tlMax = (tl == 32'hFFFF_FFFF);
    assign oIrq  = tcon[1] & tcon[2];

    // Software writes to TL/TCON take priority over counting and status set.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            th    <= '0;
            tl    <= '0;
            tcon  <= '0;
            oLed  <= '0;
            oDigi <= '0;
            sw1   <= '0;
            sw2   <= '0;
        end else begin
            sw1 <= iSwitch;
            sw2 <= sw1;
            if (wrTh) th <= iWrData;
            if (wrTl) begin
                tl <= iWrData;
            end else if (tcon[0]) begin
                tl <= tlMax ? th : tl + 32'd1;
            end
            if (wrTcon) begin
                tcon <= iWrData[2:0];
            end else if (!wrTl && tcon[0] && tcon[1] && tlMax) begin
                tcon[2] <= 1'b1;
            end
            if (wrLed)  oLed  <= iWrData[7:0];
            if (wrDigi) oDigi <= iWrData[11:0];
        end
    end

    logic [31:0] uartRd;

`ifdef UART_TX_EN
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uartState_t;

    uartState_t  state, stateNx;
    logic [15:0] baudCnt, baudCntNx;
    logic [2:0]  bitIdx, bitIdxNx;
    logic [7:0]  txByte, txByteNx;
    logic        done, doneNx;
    logic        busy;
    logic        baudEnd;
    logic        txdWr;
    logic        conRd;
    logic        txBit;

    assign busy    = (state != IDLE);
    assign baudEnd = (baudCnt == 16'(CLKS_PER_BIT - 1));
    assign txdWr   = perWr & (offs == 6'h06);
    assign conRd   = iMemRead & perSel & (offs == 6'h07);
    assign oUartTx = txBit;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state   <= IDLE;
            baudCnt <= '0;
            bitIdx  <= '0;
            txByte  <= '0;
            done    <= 1'b0;
        end else begin
            state   <= stateNx;
            baudCnt <= baudCntNx;
            bitIdx  <= bitIdxNx;
            txByte  <= txByteNx;
            done    <= doneNx;
        end
    end

    // Clear-on-read is applied first so the STOP->IDLE done-set overrides it.
    always_comb begin
        stateNx   = state;
        baudCntNx = baudCnt;
        bitIdxNx  = bitIdx;
        txByteNx  = txByte;
        doneNx    = done;
        txBit     = 1'b1;
        if (conRd) doneNx = 1'b0;
        case (state)
            IDLE: begin
                if (txdWr) begin
                    stateNx   = START;
                    baudCntNx = '0;
                    bitIdxNx  = '0;
                    txByteNx  = iWrData[7:0];
                end
            end
            START: begin
                txBit = 1'b0;
                if (baudEnd) begin
                    stateNx   = DATA;
                    baudCntNx = '0;
                end else begin
                    baudCntNx = baudCnt + 16'd1;
                end
            end
            DATA: begin
                txBit = txByte[bitIdx];
                if (baudEnd) begin
                    baudCntNx = '0;
                    bitIdxNx  = bitIdx + 3'd1;
                    if (bitIdx == 3'd7) stateNx = STOP;
                end else begin
                    baudCntNx = baudCnt + 16'd1;
                end
            end
            STOP: begin
                if (baudEnd) begin
                    stateNx   = IDLE;
                    baudCntNx = '0;
                    doneNx    = 1'b1;
                end else begin
                    baudCntNx = baudCnt + 16'd1;
                end
            end
        endcase
    end

    assign uartRd = (offs == 6'h07) ? {30'd0, done, busy} : 32'd0;
`else
    logic unusedUart;

    assign unusedUart = ^{iMemRead, 16'(CLKS_PER_BIT)};
    assign uartRd     = 32'd0;
    assign oUartTx    = 1'b1;
`endif

    logic [31:0] perRd;
    logic [1:0]  unusedAddr;

    assign unusedAddr = iAddr[1:0];

    always_comb begin
        perRd = '0;
        case (offs)
            6'h00:   perRd = th;
            6'h01:   perRd = tl;
            6'h02:   perRd = {29'd0, tcon};
            6'h03:   perRd = {24'd0, oLed};
            6'h04:   perRd = {24'd0, sw2};
            6'h05:   perRd = {20'd0, oDigi};
            6'h06,
            6'h07:   perRd = uartRd;
            default: perRd = '0;
        endcase
    end

    assign oRdData = ramSel ? iRamRdData :
                     perSel ? perRd      : 32'd0;

endmodule

// File: tb/tb_singcyc_periph_bus.sv
// tb_singcyc_periph_bus: directed bench for singcyc_periph_bus.
// Build with +define+UART_TX_EN to exercise the UART; otherwise UART reads 0.
module tb_singcyc_periph_bus;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_DIGI = 32'h4000_0014;
    localparam logic [31:0] A_TXD  = 32'h4000_0018;
    localparam logic [31:0] A_UCON = 32'h4000_001C;

    logic        iClk;
    logic        iRst_n;
    logic [31:0] iAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iWrData;
    logic [31:0] oRdData;
    logic        oRamWrite;
    logic [31:0] iRamRdData;
    logic [7:0]  iSwitch;
    logic [7:0]  oLed;
    logic [11:0] oDigi;
    logic        oIrq;
    logic        oUartTx;

    int nTests;
    int nFail;

    singcyc_periph_bus #(
        .CLKS_PER_BIT(4)
    ) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iAddr     (iAddr),
        .iMemRead  (iMemRead),
        .iMemWrite (iMemWrite),
        .iWrData   (iWrData),
        .oRdData   (oRdData),
        .oRamWrite (oRamWrite),
        .iRamRdData(iRamRdData),
        .iSwitch   (iSwitch),
        .oLed      (oLed),
        .oDigi     (oDigi),
        .oIrq      (oIrq),
        .oUartTx   (oUartTx)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic busWr(input logic [31:0] a, input logic [31:0] d);
        iAddr     = a;
        iWrData   = d;
        iMemWrite = 1'b1;
        @(posedge iClk);
        #1;
        iMemWrite = 1'b0;
    endtask

    task automatic busRd(input logic [31:0] a, output logic [31:0] d);
        iAddr    = a;
        iMemRead = 1'b1;
        #1;
        d = oRdData;
        @(posedge iClk);
        #1;
        iMemRead = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        busWr(A_LED, 32'hFF);
        busWr(A_DIGI, 32'hABC);
        busWr(A_TH, 32'h1234);
        busWr(A_TCON, 32'h3);
        #2;
        iRst_n = 1'b0;
        #1;
        nTests++;
        if (oLed !== 8'h00) begin
            nFail++;
            $display("FAIL reset_led got %h want 00", oLed);
        end
        nTests++;
        if (oDigi !== 12'h000) begin
            nFail++;
            $display("FAIL reset_digi got %h want 000", oDigi);
        end
        nTests++;
        if (oIrq !== 1'b0 || oUartTx !== 1'b1) begin
            nFail++;
            $display("FAIL reset_irq_tx got irq=%b tx=%b want 0/1", oIrq, oUartTx);
        end
        iAddr = A_TCON;
        #1;
        nTests++;
        if (oRdData !== 32'h0) begin
            nFail++;
            $display("FAIL reset_tcon got %h want 0", oRdData);
        end
        @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        busRd(A_TH, d);
        nTests++;
        if (d !== 32'h0) begin
            nFail++;
            $display("FAIL reset_th got %h want 0", d);
        end
        busRd(A_TL, d);
        nTests++;
        if (d !== 32'h0) begin
            nFail++;
            $display("FAIL reset_tl got %h want 0", d);
        end
    endtask

    task automatic test_decode;
        logic [31:0] d;
        iRamRdData = 32'h1234_5678;
        iAddr      = 32'h0000_0010;
        iWrData    = 32'hDEAD_BEEF;
        iMemWrite  = 1'b1;
        #1;
        nTests++;
        if (oRamWrite !== 1'b1) begin
            nFail++;
            $display("FAIL ram_write got %b want 1", oRamWrite);
        end
        @(posedge iClk);
        #1;
        iMemWrite = 1'b0;
        busRd(32'h0000_0010, d);
        nTests++;
        if (d !== 32'h1234_5678) begin
            nFail++;
            $display("FAIL ram_read got %h want 12345678", d);
        end
        iAddr     = 32'h8000_0000;
        iMemWrite = 1'b1;
        #1;
        nTests++;
        if (oRamWrite !== 1'b0) begin
            nFail++;
            $display("FAIL unmapped_write got %b want 0", oRamWrite);
        end
        @(posedge iClk);
        #1;
        iMemWrite = 1'b0;
        busRd(32'h8000_0000, d);
        nTests++;
        if (d !== 32'h0) begin
            nFail++;
            $display("FAIL unmapped_read got %h want 0", d);
        end
        iAddr     = A_LED;
        iWrData   = 32'hA5;
        iMemWrite = 1'b1;
        #1;
        nTests++;
        if (oRamWrite !== 1'b0) begin
            nFail++;
            $display("FAIL periph_ramwr got %b want 0", oRamWrite);
        end
        @(posedge iClk);
        #1;
        iMemWrite = 1'b0;
        nTests++;
        if (oLed !== 8'hA5) begin
            nFail++;
            $display("FAIL led_out got %h want a5", oLed);
        end
        busRd(32'h4000_000E, d);
        nTests++;
        if (d !== 32'hA5) begin
            nFail++;
            $display("FAIL led_read_lowbits got %h want a5", d);
        end
        busWr(A_DIGI, 32'hFFFF_F123);
        nTests++;
        if (oDigi !== 12'h123) begin
            nFail++;
            $display("FAIL digi_out got %h want 123", oDigi);
        end
        busRd(A_DIGI, d);
        nTests++;
        if (d !== 32'h123) begin
            nFail++;
            $display("FAIL digi_read got %h want 123", d);
        end
        busWr(32'h4000_0020, 32'hFFFF_FFFF);
        busRd(32'h4000_0020, d);
        nTests++;
        if (d !== 32'h0) begin
            nFail++;
            $display("FAIL bad_offset got %h want 0", d);
        end
        busWr(32'h4000_0100, 32'h77);
        nTests++;
        if (oLed !== 8'hA5) begin
            nFail++;
            $display("FAIL near_miss_led got %h want a5", oLed);
        end
    endtask

    task automatic test_timer;
        logic [31:0] d;
        busWr(A_TH, 32'hFFFF_FFFC);
        busWr(A_TL, 32'hFFFF_FFFE);
        busWr(A_TCON, 32'h3);
        busRd(A_TL, d);
        nTests++;
        if (d !== 32'hFFFF_FFFE) begin
            nFail++;
            $display("FAIL timer_t0 got %h want fffffffe", d);
        end
        nTests++;
        if (oIrq !== 1'b0) begin
            nFail++;
            $display("FAIL timer_irq_early got %b want 0", oIrq);
        end
        busRd(A_TL, d);
        nTests++;
        if (d !== 32'hFFFF_FFFF) begin
            nFail++;
            $display("FAIL timer_t1 got %h want ffffffff", d);
        end
        nTests++;
        if (oIrq !== 1'b1) begin
            nFail++;
            $display("FAIL timer_irq got %b want 1", oIrq);
        end
        busRd(A_TL, d);
        nTests++;
        if (d !== 32'hFFFF_FFFC) begin
            nFail++;
            $display("FAIL timer_reload got %h want fffffffc", d);
        end
        busRd(A_TCON, d);
        nTests++;
        if (d !== 32'h7) begin
            nFail++;
            $display("FAIL timer_tcon got %h want 7", d);
        end
        busWr(A_TCON, 32'h3);
        nTests++;
        if (oIrq !== 1'b0) begin
            nFail++;
            $display("FAIL timer_irq_clear got %b want 0", oIrq);
        end
        busWr(A_TCON, 32'h0);
    endtask

    task automatic test_precedence;
        logic [31:0] d;
        busWr(A_TH, 32'h100);
        busWr(A_TL, 32'hFFFF_FFFE);
        busWr(A_TCON, 32'h3);
        idle(1);
        busWr(A_TL, 32'h5);
        nTests++;
        if (oIrq !== 1'b0) begin
            nFail++;
            $display("FAIL prec_irq got %b want 0", oIrq);
        end
        busRd(A_TCON, d);
        nTests++;
        if (d !== 32'h3) begin
            nFail++;
            $display("FAIL prec_tcon got %h want 3", d);
        end
        busRd(A_TL, d);
        nTests++;
        if (d !== 32'h6) begin
            nFail++;
            $display("FAIL prec_tl got %h want 6", d);
        end
        busWr(A_TCON, 32'h0);
    endtask

    task automatic test_switch;
        logic [31:0] d;
        iSwitch = 8'h3C;
        busRd(A_SW, d);
        nTests++;
        if (d !== 32'h0) begin
            nFail++;
            $display("FAIL sw_edge0 got %h want 0", d);
        end
        busRd(A_SW, d);
        nTests++;
        if (d !== 32'h0) begin
            nFail++;
            $display("FAIL sw_edge1 got %h want 0", d);
        end
        busRd(A_SW, d);
        nTests++;
        if (d !== 32'h3C) begin
            nFail++;
            $display("FAIL sw_edge2 got %h want 3c", d);
        end
        busWr(A_SW, 32'h0);
        busRd(A_SW, d);
        nTests++;
        if (d !== 32'h3C) begin
            nFail++;
            $display("FAIL sw_ro got %h want 3c", d);
        end
    endtask

`ifdef UART_TX_EN
    task automatic test_uart;
        logic [31:0] d;
        logic [9:0]  frame;
        int          bad;
        frame = {1'b1, 8'h55, 1'b0};
        bad   = 0;
        busWr(A_TXD, 32'h55);
        for (int k = 0; k < 40; k++) begin
            if (oUartTx !== frame[k/4]) begin
                bad++;
                $display("FAIL uart_bit k=%0d got %b want %b", k, oUartTx, frame[k/4]);
            end
            if (k == 10) begin
                iAddr = A_UCON;
                #1;
                nTests++;
                if (oRdData !== 32'h1) begin
                    nFail++;
                    $display("FAIL uart_busy got %h want 1", oRdData);
                end
            end
            if (k == 5) begin
                iAddr     = A_TXD;
                iWrData   = 32'hFF;
                iMemWrite = 1'b1;
            end
            @(posedge iClk);
            #1;
            iMemWrite = 1'b0;
        end
        nTests++;
        if (bad != 0) begin
            nFail++;
            $display("FAIL uart_frame got %0d bad bits want 0", bad);
        end
        nTests++;
        if (oUartTx !== 1'b1) begin
            nFail++;
            $display("FAIL uart_idle got %b want 1", oUartTx);
        end
        busRd(A_UCON, d);
        nTests++;
        if (d !== 32'h2) begin
            nFail++;
            $display("FAIL uart_done got %h want 2", d);
        end
        busRd(A_UCON, d);
        nTests++;
        if (d !== 32'h0) begin
            nFail++;
            $display("FAIL uart_done_clr got %h want 0", d);
        end
        busRd(A_TXD, d);
        nTests++;
        if (d !== 32'h0 || oUartTx !== 1'b1) begin
            nFail++;
            $display("FAIL uart_txd_rd got %h tx=%b want 0/1", d, oUartTx);
        end
        busWr(A_TXD, 32'h00);
        idle(6);
        nTests++;
        if (oUartTx !== 1'b0) begin
            nFail++;
            $display("FAIL uart_mid got %b want 0", oUartTx);
        end
        #2;
        iRst_n = 1'b0;
        #1;
        nTests++;
        if (oUartTx !== 1'b1) begin
            nFail++;
            $display("FAIL uart_rst_tx got %b want 1", oUartTx);
        end
        @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        busRd(A_UCON, d);
        nTests++;
        if (d !== 32'h0) begin
            nFail++;
            $display("FAIL uart_rst_con got %h want 0", d);
        end
    endtask
`else
    task automatic test_uart;
        logic [31:0] d;
        busWr(A_TXD, 32'h55);
        idle(3);
        nTests++;
        if (oUartTx !== 1'b1) begin
            nFail++;
            $display("FAIL uart_off_tx got %b want 1", oUartTx);
        end
        busRd(A_UCON, d);
        nTests++;
        if (d !== 32'h0) begin
            nFail++;
            $display("FAIL uart_off_con got %h want 0", d);
        end
        busRd(A_TXD, d);
        nTests++;
        if (d !== 32'h0) begin
            nFail++;
            $display("FAIL uart_off_txd got %h want 0", d);
        end
    endtask
`endif

    initial begin
        nTests     = 0;
        nFail      = 0;
        iRst_n     = 1'b0;
        iAddr      = '0;
        iMemRead   = 1'b0;
        iMemWrite  = 1'b0;
        iWrData    = '0;
        iRamRdData = '0;
        iSwitch    = '0;
        idle(2);
        iRst_n = 1'b1;
        idle(1);
        test_reset;
        test_decode;
        test_timer;
        test_precedence;
        test_switch;
        test_uart;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
